// File: rtl/sys_array_feeder.sv
// Operand sequencer and result drainer for NDP_unit: streams K columns of A and
// K rows of B into the array, waits for the result, then drains it row by row.
module sys_array_feeder #(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int SYS_HEIGHT = 1,
  parameter int SYS_WIDTH  = 64,
  parameter int K_MAX      = 16,
  parameter int ADDR_W     = 10
) (
  input  logic                                                         clk,
  input  logic                                                         reset,
  input  logic                                                         start,
  input  logic [$clog2(K_MAX+1)-1:0]                                   k_len,
  input  logic [ADDR_W-1:0]                                            a_base,
  input  logic [ADDR_W-1:0]                                            b_base,
  output logic                                                         busy,
  output logic                                                         done,
  output logic                                                         err,
  output logic                                                         a_rd_en,
  output logic [ADDR_W-1:0]                                            a_rd_addr,
  input  logic [SYS_HEIGHT*ARR_HEIGHT*WIDTH-1:0]                       a_rd_data,
  output logic                                                         b_rd_en,
  output logic [ADDR_W-1:0]                                            b_rd_addr,
  input  logic [SYS_WIDTH*ARR_WIDTH*WIDTH-1:0]                         b_rd_data,
  output logic                                                         sa_reset,
  output logic [SYS_HEIGHT*ARR_HEIGHT*WIDTH-1:0]                       in_a,
  output logic [SYS_WIDTH*ARR_WIDTH*WIDTH-1:0]                         in_b,
  output logic                                                         in_done_flag,
  input  logic                                                         calc_done_flag,
  input  logic [SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH-1:0]   out_c,
  output logic                                                         res_valid,
  input  logic                                                         res_ready,
  output logic [$clog2(SYS_HEIGHT*ARR_HEIGHT)-1:0]                     res_row_idx,
  output logic [SYS_WIDTH*ARR_WIDTH*WIDTH-1:0]                         res_data
);
  localparam int R  = SYS_HEIGHT * ARR_HEIGHT;
  localparam int N  = SYS_WIDTH * ARR_WIDTH;
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = $clog2(R);

  // FLUSH covers the two-cycle buffer-read plus in_a register latency.
  typedef enum logic [2:0] {IDLE, CLR, FEED, FLUSH, FLAG, WAIT, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [KW-1:0]     k_q, cnt;
  logic [ADDR_W-1:0] a_base_q, b_base_q;
  logic [RW-1:0]     row;
  logic              rd_vld;
  logic              k_ok, feed, last_row;
  logic [N*WIDTH-1:0] res_rows [R];

  assign k_ok     = (k_len != '0) && (k_len <= KW'(K_MAX));
  assign last_row = (row == RW'(R - 1));

  always_comb begin
    state_nxt    = state;
    feed         = 1'b0;
    busy         = (state != IDLE);
    sa_reset     = reset || (state == CLR);
    in_done_flag = (state == FLAG) || (state == WAIT);
    res_valid    = (state == DRAIN);
    res_row_idx  = '0;
    res_data     = '0;
    case (state)
      IDLE:  if (start && k_ok) state_nxt = CLR;
      CLR:   state_nxt = FEED;
      FEED: begin
        feed = 1'b1;
        if (cnt == k_q - KW'(1)) state_nxt = FLUSH;
      end
      FLUSH: if (cnt == KW'(1)) state_nxt = FLAG;
      FLAG:  state_nxt = WAIT;
      WAIT:  if (calc_done_flag) state_nxt = DRAIN;
      DRAIN: begin
        res_row_idx = row;
        res_data    = res_rows[row];
        if (res_ready && last_row) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    a_rd_en   = feed;
    b_rd_en   = feed;
    a_rd_addr = feed ? a_base_q + ADDR_W'(cnt) : '0;
    b_rd_addr = feed ? b_base_q + ADDR_W'(cnt) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      cnt      <= '0;
      row      <= '0;
      rd_vld   <= 1'b0;
      in_a     <= '0;
      in_b     <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= (state == IDLE) && start && !k_ok;
      done  <= (state == DRAIN) && res_ready && last_row;
      if (state == IDLE && start && k_ok) begin
        k_q      <= k_len;
        a_base_q <= a_base;
        b_base_q <= b_base;
      end
      if ((state == FEED || state == FLUSH) && state_nxt == state) cnt <= cnt + KW'(1);
      else                                                         cnt <= '0;
      if (state != DRAIN)  row <= '0;
      else if (res_ready)  row <= last_row ? '0 : row + RW'(1);
      // Zero the array inputs in every cycle that does not carry a column.
      rd_vld <= feed;
      in_a   <= rd_vld ? a_rd_data : '0;
      in_b   <= rd_vld ? b_rd_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == WAIT && calc_done_flag) begin
      for (int r = 0; r < R; r++) res_rows[r] <= out_c[r*N*WIDTH +: N*WIDTH];
    end
  end
endmodule

// File: tb/tb_sys_array_feeder.sv
// Directed bench for sys_array_feeder: commands push expected reads, columns,
// flags and rows into queues; a negedge monitor pops and compares every cycle.
module tb_sys_array_feeder;
  localparam int W = 16, R = 4, N = 256, KW = 5, AW = 10, RW = 2;
  localparam int NEVER = 1 << 30;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [AW-1:0] a_base = '0, b_base = '0;
  logic busy, done, err, a_rd_en, b_rd_en, sa_reset, in_done_flag, res_valid;
  logic [AW-1:0] a_rd_addr, b_rd_addr;
  logic [R*W-1:0] a_rd_data = '0, in_a;
  logic [N*W-1:0] b_rd_data = '0, in_b, res_data;
  logic calc_done_flag = 1'b0, res_ready = 1'b1;
  logic [R*N*W-1:0] out_c = '0;
  logic [RW-1:0] res_row_idx;

  typedef struct packed { int cyc; logic [AW-1:0] a; logic [AW-1:0] b; } rd_t;
  typedef struct packed { int cyc; logic [R*W-1:0] a; logic [N*W-1:0] b; } col_t;
  typedef struct packed { logic [RW-1:0] idx; logic [N*W-1:0] d; } row_t;
  rd_t  rd_q[$];
  col_t col_q[$];
  row_t row_q[$];
  int   err_q[$], done_q[$];

  int cyc = 0, n_vec = 0, n_err = 0;
  int clr_cyc = -1, bstart = 0, bend = 0, flag_rise = 0, flag_fall = 0, drain_start = NEVER;
  logic prev_stall = 1'b0;

  sys_array_feeder dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .a_base(a_base), .b_base(b_base),
    .busy(busy), .done(done), .err(err),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .sa_reset(sa_reset), .in_a(in_a), .in_b(in_b), .in_done_flag(in_done_flag),
    .calc_done_flag(calc_done_flag), .out_c(out_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_row_idx(res_row_idx), .res_data(res_data)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A column: identity in the low addresses, a tagged pattern elsewhere.
  function automatic logic [R*W-1:0] a_col(input logic [AW-1:0] addr);
    logic [R*W-1:0] v;
    v = '0;
    for (int r = 0; r < R; r++) begin
      if (addr < 16) v[r*W +: W] = (int'(addr) == r) ? 16'd1 : 16'd0;
      else           v[r*W +: W] = 16'h8000 | {4'h0, addr, 2'(r)};
    end
    return v;
  endfunction

  // B row at addr: element c = c + addr[7:0] (so B[k][c] = c+k for base 0x100).
  function automatic logic [N*W-1:0] b_row(input logic [AW-1:0] addr);
    logic [N*W-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = 16'(c + int'(addr[7:0]));
    return v;
  endfunction

  function automatic logic [R*N*W-1:0] mk_out(input int seed);
    logic [R*N*W-1:0] v;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < N; c++) v[(r*N + c)*W +: W] = 16'(seed*7 + r*4099 + c*3 + 1);
    return v;
  endfunction

  // operand buffer models: one-cycle read latency, junk when not enabled
  always @(posedge clk) begin
    a_rd_data <= a_rd_en ? a_col(a_rd_addr) : '1;
    b_rd_data <= b_rd_en ? b_row(b_rd_addr) : '1;
  end

  task automatic check(input bit ok, input string what, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", what, cyc, act, exp);
    end
  endtask

  task automatic chk_vec(input string what, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    int d;
    d = -1;
    for (int i = N - 1; i >= 0; i--) if (act[i*W +: W] !== exp[i*W +: W]) d = i;
    n_vec++;
    if (d >= 0) begin
      n_err++;
      $display("FAIL %s cycle %0d element %0d: got %h, expected %h", what, cyc, d, act[d*W +: W], exp[d*W +: W]);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    rd_t  r;
    col_t c;
    bit   e, exp_v;
    check(sa_reset === (reset || cyc == clr_cyc), "sa_reset", 64'(sa_reset), 64'(reset || cyc == clr_cyc));
    check(busy === (cyc >= bstart && cyc < bend), "busy", 64'(busy), 64'(cyc >= bstart && cyc < bend));
    check(in_done_flag === (cyc >= flag_rise && cyc < flag_fall), "in_done_flag",
          64'(in_done_flag), 64'(cyc >= flag_rise && cyc < flag_fall));
    e = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
    check(a_rd_en === e && b_rd_en === e, "rd_en", {62'b0, a_rd_en, b_rd_en}, {62'b0, e, e});
    if (e) begin
      r = rd_q.pop_front();
      check(a_rd_addr === r.a, "a_rd_addr", 64'(a_rd_addr), 64'(r.a));
      check(b_rd_addr === r.b, "b_rd_addr", 64'(b_rd_addr), 64'(r.b));
    end
    if (col_q.size() > 0 && col_q[0].cyc == cyc) begin
      c = col_q.pop_front();
      chk_vec("in_a", (N*W)'(in_a), (N*W)'(c.a));
      chk_vec("in_b", in_b, c.b);
    end else begin
      chk_vec("in_a_idle", (N*W)'(in_a), '0);
      chk_vec("in_b_idle", in_b, '0);
    end
    e = (err_q.size() > 0) && (err_q[0] == cyc);
    check(err === e, "err", 64'(err), 64'(e));
    if (e) void'(err_q.pop_front());
    e = (done_q.size() > 0) && (done_q[0] == cyc);
    check(done === e, "done", 64'(done), 64'(e));
    if (e) void'(done_q.pop_front());
    exp_v = (row_q.size() > 0) && (cyc >= drain_start);
    check(res_valid === exp_v, "res_valid", 64'(res_valid), 64'(exp_v));
    if (prev_stall) check(res_valid === 1'b1, "res_valid_held", 64'(res_valid), 64'd1);
    if (exp_v && res_valid) begin
      check(res_row_idx === row_q[0].idx, "res_row_idx", 64'(res_row_idx), 64'(row_q[0].idx));
      chk_vec("res_data", res_data, row_q[0].d);
      if (res_ready) void'(row_q.pop_front());
    end
    prev_stall = res_valid && !res_ready;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input int k, input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                         input bit stall, input bit poke);
    int c0, cc, dc;
    c0 = cyc;
    start = 1'b1; k_len = KW'(k); a_base = ab; b_base = bb;
    clr_cyc = c0 + 1; bstart = c0 + 1; bend = NEVER;
    flag_rise = c0 + k + 4; flag_fall = NEVER;
    for (int i = 0; i < k; i++) begin
      rd_q.push_back('{c0 + 2 + i, ab + AW'(i), bb + AW'(i)});
      col_q.push_back('{c0 + 4 + i, a_col(ab + AW'(i)), b_row(bb + AW'(i))});
    end
    step();
    start = 1'b0; a_base = ~ab; b_base = ~bb; k_len = 5'd1;
    if (poke) begin
      step(); start = 1'b1; k_len = 5'd2;
      step(); start = 1'b0; calc_done_flag = 1'b1; out_c = {(R*N){16'hDEAD}};
      step(); calc_done_flag = 1'b0;
    end
    while (cyc < flag_rise + 5) step();
    if (poke) begin
      start = 1'b1; k_len = 5'd0;
      step(); start = 1'b0;
    end
    while (cyc < flag_rise + 20) step();
    cc = cyc;
    out_c = mk_out(cc); calc_done_flag = 1'b1;
    flag_fall = cc + 1; drain_start = cc + 1;
    for (int r = 0; r < R; r++) row_q.push_back('{RW'(r), out_c[r*N*W +: N*W]});
    dc = stall ? cc + 10 : cc + 5;
    done_q.push_back(dc); bend = dc;
    step();
    calc_done_flag = 1'b0; out_c = mk_out(cc + 77);
    while (cyc <= dc + 1) begin
      res_ready = !(stall && cyc >= cc + 3 && cyc <= cc + 7);
      step();
    end
    res_ready = 1'b1; drain_start = NEVER;
  endtask

  task automatic bad_start(input logic [KW-1:0] k);
    start = 1'b1; k_len = k; a_base = 10'h55; b_base = 10'h66;
    err_q.push_back(cyc + 1);
    step(); start = 1'b0;
    repeat (3) step();
  endtask

  task automatic abort_cmd();
    int c0;
    c0 = cyc;
    start = 1'b1; k_len = 5'd5; a_base = 10'h020; b_base = 10'h160;
    clr_cyc = c0 + 1; bstart = c0 + 1; bend = NEVER;
    flag_rise = NEVER; flag_fall = NEVER;
    rd_q.push_back('{c0 + 2, 10'h020, 10'h160});
    rd_q.push_back('{c0 + 3, 10'h021, 10'h161});
    step(); start = 1'b0;
    step();
    step(); reset = 1'b1; bend = c0 + 4;
    step(); reset = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    run_cmd(3, 10'h000, 10'h100, 1'b0, 1'b0);
    bad_start(5'd0);
    bad_start(5'd17);
    run_cmd(4, 10'h010, 10'h120, 1'b1, 1'b1);
    abort_cmd();
    run_cmd(2, 10'h030, 10'h140, 1'b0, 1'b0);
    run_cmd(3, 10'h3FF, 10'h3FE, 1'b0, 1'b1);
    repeat (3) step();
    check(rd_q.size() == 0, "rd_q_left", 64'(rd_q.size()), 64'd0);
    check(col_q.size() == 0, "col_q_left", 64'(col_q.size()), 64'd0);
    check(row_q.size() == 0, "row_q_left", 64'(row_q.size()), 64'd0);
    check(err_q.size() == 0, "err_q_left", 64'(err_q.size()), 64'd0);
    check(done_q.size() == 0, "done_q_left", 64'(done_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
